// File: rtl/spi_byte_engine_if.sv
// Control-side bus of the SPI byte engine.
// The ctrl-code decoder is the master; the engine is the slave.
interface spi_byte_engine_if #(
    parameter int DIV_W = 4
);
    logic             start;
    logic [7:0]       tx_data;
    logic [DIV_W-1:0] div;
    logic [1:0]       sel;
    logic             hold;
    logic             busy;
    logic             done;
    logic [7:0]       rx_data;

    modport master (
        output start, tx_data, div, sel, hold,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, div, sel, hold,
        output busy, done, rx_data
    );
endinterface

// File: rtl/spi_byte_engine.sv
// SPI byte sequencer: one start strobe sends a byte as 8 SCK cycles
// (mode 0, MSB first) and returns the received byte with a done pulse.
// Each non-idle phase lasts div+1 CLK cycles; nSS can be held between
// bytes to build multi-byte frames.
module spi_byte_engine #(
    parameter int DIV_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    spi_byte_engine_if.slave  bus,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [1:0]        nSS
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HI,
        LO,
        TRAIL
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic             hold_q;
    logic [6:0]       tx_sr;     // bits still to be sent after the current MOSI bit
    logic [7:0]       rx_sr;
    logic [2:0]       bitcnt;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       rx_q;
    logic             phase_end;

    assign phase_end   = (cnt == '0);
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;

    // Transfer sequencer: phase timing, bit shifting and all pin/handshake outputs.
    // NOTE: every register here uses non-blocking assignment so all of them
    // update together on the edge and read each other's previous values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            div_q  <= '0;
            hold_q <= 1'b0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            bitcnt <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rx_q   <= '0;
            SCK    <= 1'b0;
            MOSI   <= 1'b0;
            nSS    <= 2'b11;
        end else begin
            // NOTE: done defaults low here so that it can only ever be a single-cycle pulse.
            done_q <= 1'b0;

            // Half-period counter reloads on every phase exit, otherwise counts down.
            if (state != IDLE) begin
                cnt <= phase_end ? div_q : cnt - DIV_W'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx_sr  <= bus.tx_data[6:0];
                        MOSI   <= bus.tx_data[7];
                        div_q  <= bus.div;
                        cnt    <= bus.div;
                        hold_q <= bus.hold;
                        nSS    <= bus.sel;
                        bitcnt <= '0;
                        busy_q <= 1'b1;
                        state  <= LEAD;
                    end
                end

                LEAD: begin
                    if (phase_end) begin
                        SCK   <= 1'b1;
                        state <= HI;
                    end
                end

                HI: begin
                    if (phase_end) begin
                        rx_sr <= {rx_sr[6:0], MISO};
                        SCK   <= 1'b0;
                        if (bitcnt == 3'd7) begin
                            state <= TRAIL;
                        end else begin
                            MOSI   <= tx_sr[6];
                            tx_sr  <= {tx_sr[5:0], 1'b0};
                            bitcnt <= bitcnt + 3'd1;
                            state  <= LO;
                        end
                    end
                end

                LO: begin
                    if (phase_end) begin
                        SCK   <= 1'b1;
                        state <= HI;
                    end
                end

                TRAIL: begin
                    if (phase_end) begin
                        rx_q   <= rx_sr;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        if (!hold_q) begin
                            nSS <= 2'b11;
                        end
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed self-checking bench for spi_byte_engine.
// Inputs are driven and outputs sampled around the falling CLK edge.
module tb_spi_byte_engine;

    localparam int DIV_W   = 4;
    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic [1:0] nss;
    logic       loop_en  = 1'b0;
    logic       miso_val = 1'b0;

    spi_byte_engine_if #(.DIV_W(DIV_W)) bus ();

    spi_byte_engine #(.DIV_W(DIV_W)) dut (
        .CLK  (clk),
        .RST  (rst),
        .bus  (bus),
        .SCK  (sck),
        .MOSI (mosi),
        .MISO (miso),
        .nSS  (nss)
    );

    assign miso = loop_en ? mosi : miso_val;

    always #5 clk = ~clk;

    // SCK monitor: rising-edge count, MOSI at each rise, last high/low phase length, done pulses.
    int         rises     = 0;
    int         done_cnt  = 0;
    int         run       = 0;
    int         last_hi   = 0;
    int         last_lo   = 0;
    logic       sck_prev  = 1'b0;
    logic [7:0] mosi_bits = 8'h00;

    always @(negedge clk) begin
        if (sck !== sck_prev) begin
            if (sck_prev) last_hi <= run;
            else          last_lo <= run;
            run <= 1;
            if (sck) begin
                rises     <= rises + 1;
                mosi_bits <= {mosi_bits[6:0], mosi};
            end
        end else begin
            run <= run + 1;
        end
        sck_prev <= sck;
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int nss_bad;
    int busy_bad;
    int rise0;
    int done0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a byte with a one-cycle start strobe; returns just after the next falling edge.
    task automatic start_byte(input logic [7:0] tx, input logic [3:0] d,
                              input logic [1:0] s, input logic h);
        rise0        = rises;
        done0        = done_cnt;
        bus.tx_data  = tx;
        bus.div      = d;
        bus.sel      = s;
        bus.hold     = h;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        lat          = 1;
    endtask

    // Wait (bounded) for done, checking nSS and busy every cycle of the transfer.
    task automatic wait_done(input bit toggle, input int pulse_at, input logic [1:0] exp_nss);
        nss_bad  = 0;
        busy_bad = 0;
        while (bus.done !== 1'b1 && lat < TIMEOUT) begin
            if (nss !== exp_nss)     nss_bad++;
            if (bus.busy !== 1'b1)   busy_bad++;
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            if (lat == pulse_at) begin
                bus.tx_data = 8'hFF;
                bus.sel     = 2'b00;
                bus.start   = 1'b1;
            end
            if (toggle) begin
                bus.div     = ~bus.div;
                bus.sel     = ~bus.sel;
                bus.hold    = ~bus.hold;
                bus.tx_data = ~bus.tx_data;
            end
        end
        #1;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
        bus.div     = '0;
        bus.sel     = 2'b11;
        bus.hold    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_sck",  sck,         1'b0);
        check("rst_mosi", mosi,        1'b0);
        check("rst_nss",  nss,         2'b11);
        check("rst_busy", bus.busy,    1'b0);
        check("rst_done", bus.done,    1'b0);
        check("rst_rx",   bus.rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Loopback A5, div=0, sel=10: done 1+17 cycles after start
        loop_en = 1'b1;
        start_byte(8'hA5, 4'h0, 2'b10, 1'b0);
        check("lb_busy_start", bus.busy, 1'b1);
        wait_done(1'b0, -1, 2'b10);
        check("lb_latency", lat,            18);
        check("lb_rises",   rises - rise0,  8);
        check("lb_mosi",    mosi_bits,      8'hA5);
        check("lb_rx",      bus.rx_data,    8'hA5);
        check("lb_nss_run", nss_bad,        0);
        check("lb_busy_run", busy_bad,      0);
        check("lb_nss_end", nss,            2'b11);
        check("lb_busy_end", bus.busy,      1'b0);
        @(negedge clk);
        #1;
        check("lb_done_low", bus.done,        1'b0);
        check("lb_done_once", done_cnt - done0, 1);
        check("lb_sck_idle", sck,             1'b0);

        // Asynchronous reset after the third SCK rise (div=1)
        start_byte(8'h5A, 4'h1, 2'b10, 1'b0);
        while (rises - rise0 < 3 && lat < TIMEOUT) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("mid_sck_high", sck, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_sck",  sck,         1'b0);
        check("mid_rst_nss",  nss,         2'b11);
        check("mid_rst_busy", bus.busy,    1'b0);
        check("mid_rst_done", bus.done,    1'b0);
        check("mid_rst_rx",   bus.rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_done_cnt", done_cnt - done0, 0);

        // Clean byte after reset, div=1: 1+17*2 cycles
        start_byte(8'hC3, 4'h1, 2'b10, 1'b0);
        wait_done(1'b0, -1, 2'b10);
        check("clean_latency", lat,           35);
        check("clean_rx",      bus.rx_data,   8'hC3);
        check("clean_rises",   rises - rise0, 8);
        check("clean_nss_run", nss_bad,       0);

        // Maximum divider, MISO held high, tx=00
        loop_en  = 1'b0;
        miso_val = 1'b1;
        start_byte(8'h00, 4'hF, 2'b10, 1'b0);
        wait_done(1'b0, -1, 2'b10);
        check("div_latency", lat,         273);
        check("div_hi_len",  last_hi,     16);
        check("div_lo_len",  last_lo,     16);
        check("div_rx",      bus.rx_data, 8'hFF);
        check("div_mosi",    mosi_bits,   8'h00);
        check("div_rises",   rises - rise0, 8);

        // Hold chain: 12 with hold, then 34 started in the done cycle
        loop_en = 1'b1;
        start_byte(8'h12, 4'h0, 2'b01, 1'b1);
        wait_done(1'b0, -1, 2'b01);
        check("hold1_latency", lat,         18);
        check("hold1_rx",      bus.rx_data, 8'h12);
        check("hold1_nss_run", nss_bad,     0);
        check("hold1_nss_kept", nss,        2'b01);
        check("hold1_sck_low", sck,         1'b0);
        start_byte(8'h34, 4'h0, 2'b01, 1'b0);
        check("hold2_busy_now", bus.busy,   1'b1);
        check("hold2_nss_now",  nss,        2'b01);
        wait_done(1'b0, -1, 2'b01);
        check("hold2_latency", lat,         18);
        check("hold2_rx",      bus.rx_data, 8'h34);
        check("hold2_mosi",    mosi_bits,   8'h34);
        check("hold2_nss_run", nss_bad,     0);
        check("hold2_nss_end", nss,         2'b11);

        // Start pulse with FF in the middle of a 3C transfer is ignored
        start_byte(8'h3C, 4'h0, 2'b10, 1'b0);
        wait_done(1'b0, 5, 2'b10);
        check("ign_latency",  lat,         18);
        check("ign_mosi",     mosi_bits,   8'h3C);
        check("ign_rx",       bus.rx_data, 8'h3C);
        check("ign_busy_run", busy_bad,    0);
        check("ign_nss_run",  nss_bad,     0);
        @(negedge clk);
        #1;
        check("ign_done_once", done_cnt - done0, 1);
        check("ign_idle",      bus.busy,         1'b0);

        // Inputs toggling every cycle during busy follow the values latched at start
        start_byte(8'h96, 4'h2, 2'b10, 1'b0);
        wait_done(1'b1, -1, 2'b10);
        check("tog_latency", lat,         52);
        check("tog_hi_len",  last_hi,     3);
        check("tog_lo_len",  last_lo,     3);
        check("tog_mosi",    mosi_bits,   8'h96);
        check("tog_rx",      bus.rx_data, 8'h96);
        check("tog_nss_run", nss_bad,     0);
        check("tog_nss_end", nss,         2'b11);
        bus.start = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
